pid_channel_scheduler: RTL

Time-multiplexes one shared PID arithmetic unit across NUM_CH motor channels. On each control tick it snapshots all per-channel error words from the HPS error PIOs and issues them to the PID unit in channel order over a valid/ready request and response handshake. Results are clamped and stored in per-channel correction registers that feed the correction PIOs and PWM path. Sits between the HPS PIO bank and the PID core, and owns the control-loop period, e-stop gating and overrun accounting.

---
 rtl/pid_channel_scheduler.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pid_channel_scheduler.sv
// Time-multiplexes one PID arithmetic unit across NUM_CH channels: snapshots errors per
// control tick, issues them in order over valid/ready, clamps and stores the results.
module pid_channel_scheduler #(
  parameter int unsigned              NUM_CH      = 8,
  parameter int unsigned              DATA_W      = 32,
  parameter logic signed [DATA_W-1:0] CORR_LIMIT  = 32'sd1000000,
  parameter int unsigned              RSP_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [31:0]              period,
  input  logic [NUM_CH*DATA_W-1:0] err_in,
  input  logic                     e_stop,
  output logic                     pid_req_valid,
  input  logic                     pid_req_ready,
  output logic [3:0]               pid_req_ch,
  output logic [DATA_W-1:0]        pid_req_err,
  input  logic                     pid_rsp_valid,
  input  logic [DATA_W-1:0]        pid_rsp_data,
  output logic [NUM_CH*DATA_W-1:0] corr_out,
  output logic                     sweep_done,
  output logic                     busy,
  output logic                     timeout_flag,
  output logic [15:0]              overrun_cnt
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_STORE,
    ST_DONE
  } state_t;

  state_t                         state;
  logic [31:0]                    tick_cnt;
  logic [31:0]                    p_eff;
  logic                           tick;
  logic [NUM_CH-1:0][DATA_W-1:0]  snap;
  logic [NUM_CH-1:0][DATA_W-1:0]  corr;
  logic [DATA_W-1:0]              res;
  logic [15:0]                    to_cnt;
  logic [CH_W-1:0]                ch_idx;
  logic [CH_W-1:0]                nxt_idx;

  assign corr_out = corr;
  assign ch_idx   = pid_req_ch[CH_W-1:0];
  assign nxt_idx  = ch_idx + CH_W'(1);

  function automatic logic [DATA_W-1:0] clamp(input logic signed [DATA_W-1:0] v);
    if (v > CORR_LIMIT)
      return CORR_LIMIT;
    else if (v < -CORR_LIMIT)
      return -CORR_LIMIT;
    else
      return v;
  endfunction

  // >= rather than == so a period shrunk below the running count still wraps at once
  always_comb begin
    p_eff = (period < 32'd2) ? 32'd2 : period;
    tick  = enable && (tick_cnt >= p_eff - 32'd1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      tick_cnt <= '0;
    else if (!enable || tick)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      snap          <= '0;
      corr          <= '0;
      res           <= '0;
      to_cnt        <= '0;
      pid_req_valid <= 1'b0;
      pid_req_ch    <= '0;
      pid_req_err   <= '0;
      sweep_done    <= 1'b0;
      busy          <= 1'b0;
      timeout_flag  <= 1'b0;
      overrun_cnt   <= '0;
    end else begin
      sweep_done <= 1'b0;
      if (tick && state != ST_IDLE && overrun_cnt != '1)
        overrun_cnt <= overrun_cnt + 16'd1;

      case (state)
        ST_IDLE: begin
          if (tick) begin
            snap          <= err_in;
            pid_req_ch    <= '0;
            pid_req_err   <= err_in[DATA_W-1:0];
            pid_req_valid <= 1'b1;
            busy          <= 1'b1;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (pid_req_ready) begin
            pid_req_valid <= 1'b0;
            to_cnt        <= '0;
            state         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // a response in the timeout cycle takes priority over abandoning the channel
          if (pid_rsp_valid) begin
            res   <= clamp(pid_rsp_data);
            state <= ST_STORE;
          end else if (to_cnt == 16'(RSP_TIMEOUT - 1)) begin
            res          <= '0;
            timeout_flag <= 1'b1;
            state        <= ST_STORE;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        ST_STORE: begin
          corr[ch_idx] <= e_stop ? '0 : res;
          if (pid_req_ch == 4'(NUM_CH - 1)) begin
            sweep_done <= 1'b1;
            state      <= ST_DONE;
          end else begin
            pid_req_ch    <= pid_req_ch + 4'd1;
            pid_req_err   <= snap[nxt_idx];
            pid_req_valid <= 1'b1;
            state         <= ST_ISSUE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (e_stop)
        corr <= '0;
    end
  end

endmodule
